// File: rtl/rll_pkg.sv
// rtl/rll_pkg.sv - shared types and helpers for the keyed output stage
package rll_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        ARMED   = 2'd2
    } rll_key_state_e;

    // Key that makes every gate transparent; masks wider than 64 bits are not supported.
    function automatic logic [63:0] rll_correct_key(input logic [63:0] xnor_mask,
                                                    input logic [63:0] inv_mask);
        return xnor_mask ^ inv_mask;
    endfunction

endpackage

// File: rtl/rll_key_shifter.sv
// rtl/rll_key_shifter.sv - serial key loader: shift register, bit counter and arming FSM
module rll_key_shifter
    import rll_pkg::*;
#(
    parameter int KEY_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic             key_bit,
    input  logic             key_clear,
    output logic             key_ready,
    output logic [KEY_W-1:0] key,
    output logic             armed
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);

    rll_key_state_e   r_state;
    logic [KEY_W-1:0] r_key;
    logic [CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0] w_shifted;
    logic             w_accept;

    assign key_ready = (r_state != ARMED) && !key_clear;
    assign w_accept  = key_valid && key_ready;
    // New bit enters at the top so the first received bit ends up in key[0].
    assign w_shifted = KEY_W'({key_bit, r_key} >> 1);

    always_ff @(posedge clk) begin
        if (rst || key_clear) begin
            r_state <= EMPTY;
            r_key   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_key <= w_shifted;
            if (r_cnt != CNT_FULL) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_state <= (r_cnt == CNT_LAST) ? ARMED : LOADING;
        end
    end

    assign key   = r_key;
    assign armed = (r_state == ARMED);

endmodule

// File: rtl/rll_keyed_stage.sv
// rtl/rll_keyed_stage.sv - key-gated registered valid/ready output stage of a locked datapath
module rll_keyed_stage
    import rll_pkg::*;
#(
    parameter int               DATA_W    = 32,
    parameter int               KEY_W     = 16,
    parameter logic [KEY_W-1:0] XNOR_MASK = 16'hA5C3,
    parameter logic [KEY_W-1:0] INV_MASK  = 16'h0F0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic              key_bit,
    output logic              key_ready,
    input  logic              key_clear,
    output logic              key_loaded,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    // XNOR and inverter stages fold into a constant XOR term per bit.
    localparam logic [KEY_W-1:0] GATE_MASK = XNOR_MASK ^ INV_MASK;

    logic [KEY_W-1:0]  w_key;
    logic              w_armed;
    logic [DATA_W-1:0] w_gated;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    rll_key_shifter #(
        .KEY_W(KEY_W)
    ) u_key_shifter (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_bit  (key_bit),
        .key_clear(key_clear),
        .key_ready(key_ready),
        .key      (w_key),
        .armed    (w_armed)
    );

    assign w_gated  = in_data ^ DATA_W'(w_key ^ GATE_MASK);
    assign in_ready = w_armed && (!r_out_valid || out_ready) && !key_clear;

    always_ff @(posedge clk) begin
        if (rst || key_clear) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (in_valid && in_ready) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gated;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign key_loaded = w_armed;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

endmodule

// File: tb/tb_rll_keyed_stage.sv
// tb/tb_rll_keyed_stage.sv - randomized scoreboard bench for rll_keyed_stage
module tb_rll_keyed_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic        key_bit;
    logic        key_ready;
    logic        key_clear;
    logic        key_loaded;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [15:0] model_key = 16'h0000;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = 32'h0;

    rll_keyed_stage dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_bit   (key_bit),
        .key_ready (key_ready),
        .key_clear (key_clear),
        .key_loaded(key_loaded),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // 16'hAACC is the key that leaves data untouched; any other key XORs its difference in.
    function automatic logic [31:0] model(input logic [31:0] d);
        return d ^ {16'h0000, model_key ^ 16'hAACC};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bits(input logic [15:0] k, input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            key_valid = 1'b1;
            key_bit   = k[i];
            @(negedge clk);
            chk("key_ready_loading", key_ready, 1);
            chk("key_loaded_early", key_loaded, 0);
            tick();
        end
        key_valid = 1'b0;
        if (full) begin
            model_key = k;
            @(negedge clk);
            chk("key_loaded_after_load", key_loaded, 1);
            chk("key_ready_armed", key_ready, 0);
            if (out_ready && !out_valid) chk("in_ready_after_load", in_ready, 1);
            tick();
        end
    endtask

    task automatic send(input logic [31:0] d, input bit rnd_ready);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 200 && !done; n++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(d));
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
        if (rst || key_clear) exp_q.delete();
        prev_hold = out_valid && !out_ready && !rst && !key_clear;
        prev_data = out_data;
    end

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_bit = 1'b0; key_clear = 1'b0;
        in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_key_ready", key_ready, 1);
        chk("rst_key_loaded", key_loaded, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        tick();
        rst = 1'b0;

        load_bits(16'hAACC, 16, 1);
        send(32'h1234_5678, 0);
        @(negedge clk);
        chk("pass_valid", out_valid, 1);
        chk("pass_data", out_data, 32'h1234_5678);
        tick();

        // wrong key
        key_clear = 1'b1; tick(); key_clear = 1'b0;
        load_bits(16'h0000, 16, 1);
        send(32'h0000_0000, 0);
        @(negedge clk);
        chk("wrong_key_data", out_data, 32'h0000_AACC);
        tick();

        // backpressure with correct key
        key_clear = 1'b1; tick(); key_clear = 1'b0;
        load_bits(16'hAACC, 16, 1);
        send(32'hA000_0001, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hB000_0002;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 32'hA000_0001);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(32'hB000_0002, 0);
        send(32'hC000_0003, 0);
        send(32'hD000_0004, 0);
        repeat (2) tick();
        chk("bp_drained", exp_q.size(), 0);

        // randomized words, keys and backpressure
        for (int r = 0; r < 4; r++) begin
            logic [15:0] k;
            k = (r % 2 == 0) ? 16'hAACC : 16'($urandom);
            out_ready = 1'b1;
            key_clear = 1'b1; tick(); key_clear = 1'b0;
            load_bits(k, 16, 1);
            for (int w = 0; w < 25; w++) begin
                send($urandom, 1);
                if ($urandom_range(0, 3) == 0) tick();
            end
            out_ready = 1'b1;
            repeat (3) tick();
            chk("rand_drained", exp_q.size(), 0);
        end

        // key_clear after 9 bits, then fresh full load
        key_clear = 1'b1; tick(); key_clear = 1'b0;
        load_bits(16'h5A3C, 9, 0);
        key_clear = 1'b1;
        key_valid = 1'b1;
        @(negedge clk);
        chk("clear_key_ready", key_ready, 0);
        tick();
        key_clear = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        chk("clear_key_loaded", key_loaded, 0);
        tick();
        load_bits(16'hAACC, 16, 1);
        send(32'hCAFE_F00D, 0);
        send(32'h0BAD_BEEF, 0);
        repeat (2) tick();

        // key_clear with a pending word
        out_ready = 1'b0;
        send(32'h7777_1111, 0);
        key_clear = 1'b1;
        key_valid = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("kc_in_ready", in_ready, 0);
        tick();
        key_clear = 1'b0;
        key_valid = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("kc_out_valid", out_valid, 0);
        chk("kc_out_data", out_data, 0);
        chk("kc_key_loaded", key_loaded, 0);
        chk("kc_in_ready_after", in_ready, 0);
        tick();
        out_ready = 1'b1;
        load_bits(16'h1357, 16, 1);
        send(32'h2468_ACE0, 0);
        repeat (2) tick();

        // rst mid-transfer
        out_ready = 1'b0;
        send(32'h9999_0000, 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_out_data", out_data, 0);
        chk("rst2_key_loaded", key_loaded, 0);
        chk("rst2_key_ready", key_ready, 1);
        chk("rst2_in_ready", in_ready, 0);
        tick();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst2_ignore_in", in_ready, 0);
            chk("rst2_no_out", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        load_bits(16'hAACC, 16, 1);
        send(32'h0F0F_F0F0, 0);
        repeat (3) tick();
        chk("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
